// File: rtl/mem_readback_checker.sv
// Sweeps every word of an attached memory through its read port and folds the data
// into a 32-bit rotate-XOR checksum; define MEM_READBACK_CMP_EN to add the pattern comparator.
module mem_readback_checker #(
  parameter int WID_MEM   = 2,
  parameter int DEPTH_MEM = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               hold,
  input  logic [31:0]        seed,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [31:0]        csum,
  output logic [31:0]        mism_cnt,
  output logic               fail,
  output logic [31:0]        first_fail_addr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

  state_t      r_state;
  logic [31:0] r_addr_cnt;
  logic [31:0] r_raddr;
  logic        r_i_valid;
  logic [31:0] r_i_tag;
  logic        r_d_valid;
  logic [31:0] r_d_tag;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_csum;

  logic        w_accept;
  logic [31:0] w_dout_ext;

  assign w_accept = (r_state == ST_IDLE) && start;

  // NOTE: every variable driven from always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_dout_ext                = '0;
    w_dout_ext[WID_MEM-1:0]   = dout;
  end

  // The issue stage tags each request with its address; the data stage lines up with dout.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_addr_cnt <= '0;
      r_raddr    <= '0;
      r_i_valid  <= 1'b0;
      r_i_tag    <= '0;
      r_d_valid  <= 1'b0;
      r_d_tag    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csum     <= '0;
    end else begin
      r_done    <= 1'b0;
      r_d_valid <= r_i_valid;
      r_d_tag   <= r_i_tag;
      if (r_d_valid) begin
        r_csum <= {r_csum[30:0], r_csum[31]} ^ w_dout_ext;
      end

      case (r_state)
        ST_IDLE: begin
          r_i_valid <= 1'b0;
          if (w_accept) begin
            r_state    <= ST_SWEEP;
            r_busy     <= 1'b1;
            r_addr_cnt <= '0;
            r_csum     <= '0;
          end
        end
        ST_SWEEP: begin
          if (!hold) begin
            r_raddr    <= r_addr_cnt;
            r_i_valid  <= 1'b1;
            r_i_tag    <= r_addr_cnt;
            r_addr_cnt <= r_addr_cnt + 32'd1;
            if (r_addr_cnt == LAST_ADDR) begin
              r_state <= ST_DRAIN;
            end
          end else begin
            // raddr is left alone; the repeated read is discarded by the cleared valid.
            r_i_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_i_valid <= 1'b0;
          // Last request is in the data stage now and accumulates on this same edge.
          if (!r_i_valid) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_i_valid <= 1'b0;
        end
      endcase
    end
  end

  assign raddr = r_raddr;
  assign busy  = r_busy;
  assign done  = r_done;
  assign csum  = r_csum;

`ifdef MEM_READBACK_CMP_EN
  logic [31:0]        r_seed;
  logic [31:0]        r_mism_cnt;
  logic               r_fail;
  logic [31:0]        r_first_fail_addr;
  logic [31:0]        w_pattern;
  logic [WID_MEM-1:0] w_expected;
  logic               w_mismatch;

  assign w_pattern  = r_d_tag ^ r_seed;
  assign w_expected = w_pattern[WID_MEM-1:0];
  assign w_mismatch = r_d_valid && (dout != w_expected);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seed            <= '0;
      r_mism_cnt        <= '0;
      r_fail            <= 1'b0;
      r_first_fail_addr <= '0;
    end else if (w_accept) begin
      r_seed            <= seed;
      r_mism_cnt        <= '0;
      r_fail            <= 1'b0;
      r_first_fail_addr <= '0;
    end else if (w_mismatch) begin
      if (r_mism_cnt != '1) begin
        r_mism_cnt <= r_mism_cnt + 32'd1;
      end
      if (!r_fail) begin
        r_fail            <= 1'b1;
        r_first_fail_addr <= r_d_tag;
      end
    end
  end

  assign mism_cnt        = r_mism_cnt;
  assign fail            = r_fail;
  assign first_fail_addr = r_first_fail_addr;
`else
  logic w_unused_cmp;
  assign w_unused_cmp    = ^{seed, r_d_tag};
  assign mism_cnt        = '0;
  assign fail            = 1'b0;
  assign first_fail_addr = '0;
`endif

endmodule

// File: tb/tb_mem_readback_checker.sv
// Directed bench for mem_readback_checker: a 4-word instance for timing/hold/reset cases
// and a 16384-word instance for full-depth checksum and comparator cases.
module tb_mem_readback_checker;

`ifdef MEM_READBACK_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk;
  logic reset;

  // Small instance (4 words)
  logic        s_start, s_hold;
  logic [31:0] s_seed, s_raddr, s_csum, s_mism, s_ffa;
  logic [1:0]  s_dout;
  logic        s_busy, s_done, s_fail;
  logic [1:0]  s_mem [4];

  // Big instance (16384 words)
  logic        b_start, b_hold, b_mode;
  logic [31:0] b_seed, b_raddr, b_csum, b_mism, b_ffa;
  logic [1:0]  b_dout;
  logic        b_busy, b_done, b_fail;

  int n_checks = 0;
  int n_errors = 0;

  mem_readback_checker #(.WID_MEM(2), .DEPTH_MEM(4)) u_dut_small (
    .clk(clk), .reset(reset), .start(s_start), .hold(s_hold), .seed(s_seed),
    .raddr(s_raddr), .dout(s_dout), .busy(s_busy), .done(s_done), .csum(s_csum),
    .mism_cnt(s_mism), .fail(s_fail), .first_fail_addr(s_ffa)
  );

  mem_readback_checker #(.WID_MEM(2), .DEPTH_MEM(16384)) u_dut_big (
    .clk(clk), .reset(reset), .start(b_start), .hold(b_hold), .seed(b_seed),
    .raddr(b_raddr), .dout(b_dout), .busy(b_busy), .done(b_done), .csum(b_csum),
    .mism_cnt(b_mism), .fail(b_fail), .first_fail_addr(b_ffa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models with one-cycle registered read latency
  always @(posedge clk) begin
    s_dout <= s_mem[s_raddr[1:0]];
    if (!b_mode)              b_dout <= 2'b00;
    else if (b_raddr == 32'd5) b_dout <= 2'b11;
    else                      b_dout <= b_raddr[1:0] ^ 2'b01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts a sweep on the small instance; hold is high for edges S+hold_from .. S+hold_from+hold_len-1.
  task automatic run_small(input int hold_from, input int hold_len,
                           output int done_at, output int busy_cnt);
    done_at  = -1;
    busy_cnt = 0;
    s_start  = 1'b1;
    tick();
    s_start = 1'b0;
    if (s_busy) busy_cnt++;
    for (int k = 1; k <= 40; k++) begin
      s_hold = (k >= hold_from) && (k < hold_from + hold_len);
      tick();
      if (s_busy) busy_cnt++;
      if (s_done) begin
        done_at = k;
        break;
      end
    end
    s_hold = 1'b0;
  endtask

  task automatic run_big(output int done_at);
    done_at = -1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 1; k <= 20000; k++) begin
      tick();
      if (b_done) begin
        done_at = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pattern_csum();
    logic [31:0] c;
    logic [31:0] w;
    c = '0;
    for (int a = 0; a < 16384; a++) begin
      w = (a == 5) ? 32'd3 : 32'((a & 3) ^ 1);
      c = {c[30:0], c[31]} ^ w;
    end
    return c;
  endfunction

  initial begin
    int done_at;
    int busy_cnt;
    int n_done;
    int d1, d2;
    logic busy_after_first;

    s_mem   = '{2'd1, 2'd2, 2'd3, 2'd0};
    reset   = 1'b0;
    s_start = 1'b0; s_hold = 1'b0; s_seed = '0;
    b_start = 1'b0; b_hold = 1'b0; b_seed = '0; b_mode = 1'b0;
    tick();
    tick();
    check("rst_raddr", s_raddr, 32'd0);
    check("rst_busy",  {31'd0, s_busy}, 32'd0);
    check("rst_done",  {31'd0, s_done}, 32'd0);
    check("rst_csum",  s_csum, 32'd0);
    check("rst_mism",  s_mism, 32'd0);
    check("rst_fail",  {31'd0, s_fail}, 32'd0);
    check("rst_ffa",   s_ffa, 32'd0);
    reset = 1'b1;
    tick();

    // Basic sweep of {1,2,3,0}
    run_small(0, 0, done_at, busy_cnt);
    check("basic_done_at", 32'(done_at), 32'd6);
    check("basic_busy_cycles", 32'(busy_cnt), 32'd6);
    check("basic_csum", s_csum, 32'h6);
    check("basic_busy_at_done", {31'd0, s_busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, s_done}, 32'd0);
    tick();
    check("csum_held", s_csum, 32'h6);

    // Three hold cycles mid-sweep
    run_small(2, 3, done_at, busy_cnt);
    check("hold_done_at", 32'(done_at), 32'd9);
    check("hold_csum", s_csum, 32'h6);
    check("hold_busy_cycles", 32'(busy_cnt), 32'd9);
    tick();

    // Reset mid-sweep, then a fresh sweep
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, s_busy}, 32'd0);
    check("abort_raddr", s_raddr, 32'd0);
    tick();
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_idle", {31'd0, s_busy}, 32'd0);
    run_small(0, 0, done_at, busy_cnt);
    check("resweep_done_at", 32'(done_at), 32'd6);
    check("resweep_csum", s_csum, 32'h6);
    tick();

    // start held high: one sweep per IDLE entry, next accepted the cycle after done
    s_start = 1'b1;
    tick();
    n_done = 0; d1 = -1; d2 = -1; busy_after_first = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 7) busy_after_first = s_busy;
      if (s_done) begin
        n_done++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    s_start = 1'b0;
    check("held_first_done", 32'(d1), 32'd6);
    check("held_second_done", 32'(d2), 32'd13);
    check("held_rearm_busy", {31'd0, busy_after_first}, 32'd1);
    check("held_done_count", 32'(n_done), 32'd3);
    tick();

    // Full depth, all-zero contents, seed 0
    b_mode = 1'b0;
    b_seed = 32'd0;
    run_big(done_at);
    check("zero_done_at", 32'(done_at), 32'd16386);
    check("zero_csum", b_csum, 32'd0);
    check("zero_mism", b_mism, 32'd0);
    check("zero_fail", {31'd0, b_fail}, 32'd0);
    tick();

    // Full depth, pattern contents with address 5 corrupted, seed 1
    b_mode = 1'b1;
    b_seed = 32'd1;
    run_big(done_at);
    check("pat_done_at", 32'(done_at), 32'd16386);
    check("pat_csum", b_csum, pattern_csum());
    check("pat_mism", b_mism, CMP ? 32'd1 : 32'd0);
    check("pat_fail", {31'd0, b_fail}, CMP ? 32'd1 : 32'd0);
    check("pat_ffa", b_ffa, CMP ? 32'd5 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
